// File: rtl/conv_accumulator.sv
// Windowed accumulator: sums KernelSize signed products, then emits a saturated
// (optionally ReLU-clamped) result over a valid/ready output with zero-bubble hand-off.
module conv_accumulator #(
  parameter int BitSize    = 32,
  parameter int KernelSize = 9,
  parameter int EnableRelu = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [BitSize-1:0] in_data,
  output logic               in_ready,
  input  logic               i_clear,
  output logic               out_valid,
  output logic [BitSize-1:0] out_data,
  input  logic               out_ready
);

  localparam int CntW = $clog2(KernelSize);
  localparam int AccW = BitSize + CntW;
  localparam logic [CntW-1:0] LastCnt = CntW'(KernelSize - 1);
  localparam logic signed [AccW-1:0] SatMax = {{(CntW + 1){1'b0}}, {(BitSize - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(CntW + 1){1'b1}}, {(BitSize - 1){1'b0}}};

  logic signed [AccW-1:0]    acc_q, acc_d;
  logic        [CntW-1:0]    cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [BitSize-1:0] out_data_q, out_data_d;
  logic signed [AccW-1:0]    in_ext;
  logic signed [AccW-1:0]    sum;
  logic                      accept;

  function automatic logic signed [BitSize-1:0] saturate(input logic signed [AccW-1:0] v);
    if (v > SatMax) return SatMax[BitSize-1:0];
    if (v < SatMin) return SatMin[BitSize-1:0];
    return v[BitSize-1:0];
  endfunction

  function automatic logic signed [BitSize-1:0] apply_relu(input logic signed [BitSize-1:0] v);
    if ((EnableRelu != 0) && (v < 0)) return '0;
    return v;
  endfunction

  assign in_ext   = {{CntW{in_data[BitSize-1]}}, in_data};
  assign sum      = acc_q + in_ext;
  // Ready is forced low during reset so nothing upstream is consumed then.
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == LastCnt) begin
        // Completing accept overrides the consume above: result hand-off without a bubble.
        out_data_d  = apply_relu(saturate(sum));
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator (BitSize=16, KernelSize=4): directed scenarios plus random
// traffic compared against a window-list reference model; one DUT without and one with ReLU.
module tb_conv_accumulator;
  localparam int BW = 16;
  localparam int K  = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, i_clear, out_ready;
  logic [BW-1:0] in_data;
  logic          in_ready, out_valid, in_ready_r, out_valid_r;
  logic [BW-1:0] out_data, out_data_r;

  int checks = 0;
  int errors = 0;

  int            m_win[$];
  logic          m_valid = 1'b0;
  logic [BW-1:0] m_data = '0;
  logic [BW-1:0] m_data_r = '0;

  always #5 clk = ~clk;

  conv_accumulator #(.BitSize(BW), .KernelSize(K), .EnableRelu(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .i_clear(i_clear), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready));

  conv_accumulator #(.BitSize(BW), .KernelSize(K), .EnableRelu(1)) dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_r),
    .i_clear(i_clear), .out_valid(out_valid_r), .out_data(out_data_r), .out_ready(out_ready));

  function automatic logic [BW-1:0] clamp16(longint s, bit relu);
    longint c;
    c = s;
    if (c > 32767) c = 32767;
    else if (c < -32768) c = -32768;
    if (relu && c < 0) c = 0;
    return c[BW-1:0];
  endfunction

  task automatic set_in(bit v, logic [BW-1:0] d, bit clr, bit ordy, bit rst);
    in_valid = v; in_data = d; i_clear = clr; out_ready = ordy; reset = rst;
  endtask

  // Advance one clock; the reference model consumes the inputs seen at that edge.
  task automatic tick();
    bit     acc, nv;
    longint s;
    acc = !reset && in_valid && (!m_valid || out_ready);
    nv  = 1'b0;
    if (reset) begin
      m_win.delete(); m_data = '0; m_data_r = '0;
    end else begin
      nv = m_valid && !out_ready;
      if (i_clear) m_win.delete();
      else if (acc) begin
        m_win.push_back(int'($signed(in_data)));
        if (m_win.size() == K) begin
          s = 0;
          foreach (m_win[i]) s += m_win[i];
          m_data = clamp16(s, 1'b0); m_data_r = clamp16(s, 1'b1);
          nv = 1'b1;
          m_win.delete();
        end
      end
    end
    @(posedge clk); #1;
    m_valid = nv;
  endtask

  task automatic test_reset();
    set_in(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < K; i++) begin
      set_in(1'b1, 16'(i + 1), 1'b0, 1'b1, 1'b0);
      tick();
      if (i < K - 1) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid cyc %0d got %b want 0", i, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 16'd10) begin errors++; $display("FAIL basic_data got %h want 000a", out_data); end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [BW-1:0] vals [2];
    logic [BW-1:0] exp_v [2];
    vals[0] = 16'h7000; exp_v[0] = 16'h7FFF;
    vals[1] = 16'h9000; exp_v[1] = 16'h8000;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < K; i++) begin
        set_in(1'b1, vals[t], 1'b0, 1'b1, 1'b0);
        tick();
      end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_v[t]) begin
        errors++; $display("FAIL saturation_%0d got v=%b d=%h want v=1 d=%h", t, out_valid, out_data, exp_v[t]);
      end
      set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < K; i++) begin
      set_in(1'b1, 16'(10 * (i + 1)), 1'b0, 1'b0, 1'b0);
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd100) begin
      errors++; $display("FAIL bp_result got v=%b d=%h want v=1 d=0064", out_valid, out_data);
    end
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'd100) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h want v=1 d=0064", c, out_valid, out_data);
      end
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] d [12];
    logic [BW-1:0] sums [3];
    int            nres;
    for (int w = 0; w < 3; w++) begin
      int s;
      s = 0;
      for (int i = 0; i < K; i++) begin
        d[w * K + i] = 16'($signed(16'($urandom_range(0, 2000))) - 16'sd1000);
        s += int'($signed(d[w * K + i]));
      end
      sums[w] = 16'(s);
    end
    nres = 0;
    for (int c = 0; c < 3 * K; c++) begin
      set_in(1'b1, d[c], 1'b0, 1'b1, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc %0d got %b want 1", c, in_ready); end
      tick();
      if (out_valid === 1'b1) begin
        checks++; if (nres > 2 || out_data !== sums[nres % 3]) begin
          errors++; $display("FAIL b2b_result %0d got %h want %h", nres, out_data, sums[nres % 3]);
        end
        nres++;
      end
    end
    checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nres); end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_clear();
    set_in(1'b1, 16'd7, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b1, 16'd7, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b1, 16'd7, 1'b1, 1'b1, 1'b0); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_valid got %b want 0", out_valid); end
    for (int i = 0; i < K; i++) begin
      set_in(1'b1, 16'd5, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd20) begin
      errors++; $display("FAIL clear_result got v=%b d=%h want v=1 d=0014", out_valid, out_data);
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 16'd3, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b1, 16'd3, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b1, 16'd9, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++; $display("FAIL rst_mid_outputs got v=%b d=%h want v=0 d=0000", out_valid, out_data);
    end
    for (int i = 0; i < K; i++) begin
      set_in(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd4) begin
      errors++; $display("FAIL rst_mid_result got v=%b d=%h want v=1 d=0004", out_valid, out_data);
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++; $display("FAIL rst_held_outputs got v=%b d=%h want v=0 d=0000", out_valid, out_data);
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_relu();
    logic [BW-1:0] p [4];
    p[0] = 16'hFFFD; p[1] = 16'hFFFE; p[2] = 16'hFFFF; p[3] = 16'hFFFF;
    for (int i = 0; i < K; i++) begin
      set_in(1'b1, p[i], 1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFF9) begin
      errors++; $display("FAIL relu_off got v=%b d=%h want v=1 d=fff9", out_valid, out_data);
    end
    checks++; if (out_valid_r !== 1'b1 || out_data_r !== 16'h0) begin
      errors++; $display("FAIL relu_on got v=%b d=%h want v=1 d=0000", out_valid_r, out_data_r);
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [BW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 400))) - 16'sd200);
      set_in($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 96) == 0);
      #1;
      checks++; if (in_ready !== (!reset && (!m_valid || out_ready))) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, in_ready, !reset && (!m_valid || out_ready));
      end
      tick();
      checks++; if (out_valid !== m_valid || out_data !== m_data) begin
        errors++; $display("FAIL rand_out cyc %0d got v=%b d=%h want v=%b d=%h", c, out_valid, out_data, m_valid, m_data);
      end
      checks++; if (out_valid_r !== m_valid || out_data_r !== m_data_r) begin
        errors++; $display("FAIL rand_relu cyc %0d got v=%b d=%h want v=%b d=%h", c, out_valid_r, out_data_r, m_valid, m_data_r);
      end
    end
  endtask

  initial begin
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_relu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
